// File: rtl/color_pkg.sv
// Shared constants and types for the colour-sensing sequencer and its classifier.
package color_pkg;

  localparam logic [2:0] COLOR_NONE    = 3'd0;
  localparam logic [2:0] COLOR_RED     = 3'd1;
  localparam logic [2:0] COLOR_GREEN   = 3'd2;
  localparam logic [2:0] COLOR_BLUE    = 3'd3;
  localparam logic [2:0] COLOR_UNKNOWN = 3'd7;

  // Filter select codes, packed as {S2,S3}
  localparam logic [1:0] FILT_RED   = 2'b00;
  localparam logic [1:0] FILT_GREEN = 2'b11;
  localparam logic [1:0] FILT_BLUE  = 2'b01;
  localparam logic [1:0] FILT_CLEAR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_DISCARD,
    ST_CAPTURE,
    ST_CLASSIFY
  } state_t;

  typedef enum logic [1:0] {
    CH_RED,
    CH_GREEN,
    CH_BLUE,
    CH_CLEAR
  } chan_t;

  function automatic logic [1:0] filt_code(input chan_t ch);
    case (ch)
      CH_RED:   return FILT_RED;
      CH_GREEN: return FILT_GREEN;
      CH_BLUE:  return FILT_BLUE;
      default:  return FILT_CLEAR;
    endcase
  endfunction

  function automatic chan_t next_chan(input chan_t ch);
    case (ch)
      CH_RED:   return CH_GREEN;
      CH_GREEN: return CH_BLUE;
      default:  return CH_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/color_classifier.sv
// Purely combinational surface-colour decision from the four captured channel counts.
module color_classifier
  import color_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MIN_CLEAR  = 50,
  parameter int DOM_MARGIN = 20
) (
  input  logic [WIDTH-1:0] red,
  input  logic [WIDTH-1:0] green,
  input  logic [WIDTH-1:0] blue,
  input  logic [WIDTH-1:0] clear,
  output logic [2:0]       color
);

  localparam logic [WIDTH-1:0] CLEAR_MIN = WIDTH'(MIN_CLEAR);
  localparam logic [WIDTH:0]   MARGIN    = (WIDTH+1)'(DOM_MARGIN);

  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] runner;
  logic [2:0]       winner;
  logic [WIDTH:0]   threshold;

  // Ties go to the earlier channel, so R beats G beats B at equal counts
  always_comb begin
    top    = red;
    runner = (green >= blue) ? green : blue;
    winner = COLOR_RED;
    if (red >= green && red >= blue) begin
      top    = red;
      runner = (green >= blue) ? green : blue;
      winner = COLOR_RED;
    end else if (green >= blue) begin
      top    = green;
      runner = (red >= blue) ? red : blue;
      winner = COLOR_GREEN;
    end else begin
      top    = blue;
      runner = (red >= green) ? red : green;
      winner = COLOR_BLUE;
    end
  end

  // One extra bit keeps the margin sum from wrapping at full-scale counts
  assign threshold = {1'b0, runner} + MARGIN;

  always_comb begin
    color = COLOR_UNKNOWN;
    if (clear < CLEAR_MIN) begin
      color = COLOR_NONE;
    end else if ({1'b0, top} >= threshold) begin
      color = winner;
    end
  end

endmodule

// File: rtl/color_sense_sequencer.sv
// Steps the sensor filters through R, G, B, clear, captures one count per channel and classifies.
// Define COLOR_AVG_EN to average two consecutive windows per channel instead of taking one.
module color_sense_sequencer
  import color_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int DISCARD_WINDOWS = 1,
  parameter int MIN_CLEAR       = 50,
  parameter int DOM_MARGIN      = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] freq_in,
  input  logic             freq_valid,
  output logic             filt_s2,
  output logic             filt_s3,
  output logic [WIDTH-1:0] red_val,
  output logic [WIDTH-1:0] green_val,
  output logic [WIDTH-1:0] blue_val,
  output logic [WIDTH-1:0] clear_val,
  output logic [2:0]       color,
  output logic             color_valid,
  output logic             busy
);

  state_t           state;
  chan_t            chan;
  logic [2:0]       disc_cnt;
  logic [WIDTH-1:0] red_cap;
  logic [WIDTH-1:0] green_cap;
  logic [WIDTH-1:0] blue_cap;
  logic [WIDTH-1:0] clear_cap;
  logic [WIDTH-1:0] cap_val;
  logic             cap_done;
  logic [2:0]       cls_color;

`ifdef COLOR_AVG_EN
  logic [WIDTH-1:0] first_win;
  logic             second_half;
  logic [WIDTH:0]   win_sum;

  // The sum carries one extra bit so the halved mean always fits back in WIDTH
  assign win_sum  = {1'b0, first_win} + {1'b0, freq_in};
  assign cap_val  = win_sum[WIDTH:1];
  assign cap_done = freq_valid && second_half;
`else
  assign cap_val  = freq_in;
  assign cap_done = freq_valid;
`endif

  color_classifier #(
    .WIDTH      (WIDTH),
    .MIN_CLEAR  (MIN_CLEAR),
    .DOM_MARGIN (DOM_MARGIN)
  ) u_classifier (
    .red   (red_cap),
    .green (green_cap),
    .blue  (blue_cap),
    .clear (clear_cap),
    .color (cls_color)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      chan        <= CH_RED;
      disc_cnt    <= 3'd0;
      red_cap     <= '0;
      green_cap   <= '0;
      blue_cap    <= '0;
      clear_cap   <= '0;
      red_val     <= '0;
      green_val   <= '0;
      blue_val    <= '0;
      clear_val   <= '0;
      color       <= COLOR_NONE;
      color_valid <= 1'b0;
      busy        <= 1'b0;
      filt_s2     <= 1'b0;
      filt_s3     <= 1'b0;
`ifdef COLOR_AVG_EN
      first_win   <= '0;
      second_half <= 1'b0;
`endif
    end else begin
      color_valid <= 1'b0;
      case (state)
        // busy still covers the color_valid cycle, so a start landing there is dropped
        ST_IDLE: begin
          if (busy) begin
            busy <= 1'b0;
          end else if (start) begin
            chan  <= CH_RED;
            busy  <= 1'b1;
            state <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          {filt_s2, filt_s3} <= filt_code(chan);
          disc_cnt           <= 3'(DISCARD_WINDOWS);
          state              <= ST_DISCARD;
        end
        ST_DISCARD: begin
          if (disc_cnt == 3'd0) begin
            state <= ST_CAPTURE;
          end else if (freq_valid) begin
            disc_cnt <= disc_cnt - 3'd1;
            if (disc_cnt == 3'd1) begin
              state <= ST_CAPTURE;
            end
          end
        end
        ST_CAPTURE: begin
`ifdef COLOR_AVG_EN
          if (freq_valid) begin
            first_win   <= freq_in;
            second_half <= !second_half;
          end
`endif
          if (cap_done) begin
            case (chan)
              CH_RED:   red_cap   <= cap_val;
              CH_GREEN: green_cap <= cap_val;
              CH_BLUE:  blue_cap  <= cap_val;
              default:  clear_cap <= cap_val;
            endcase
            if (chan == CH_CLEAR) begin
              state <= ST_CLASSIFY;
            end else begin
              chan  <= next_chan(chan);
              state <= ST_SELECT;
            end
          end
        end
        ST_CLASSIFY: begin
          red_val     <= red_cap;
          green_val   <= green_cap;
          blue_val    <= blue_cap;
          clear_val   <= clear_cap;
          color       <= cls_color;
          color_valid <= 1'b1;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_color_sense_sequencer.sv
// Scoreboard bench for color_sense_sequencer; a second instance runs with DOM_MARGIN=0 for tie cases.
module tb_color_sense_sequencer;

  localparam int DISC = 1;
`ifdef COLOR_AVG_EN
  localparam int NCAP = 2;
`else
  localparam int NCAP = 1;
`endif
  localparam logic [1:0] FCODE [4] = '{2'b00, 2'b11, 2'b01, 2'b10};

  typedef logic [31:0] win_t [8];
  typedef struct {
    logic [31:0] r;
    logic [31:0] g;
    logic [31:0] b;
    logic [31:0] c;
    logic [2:0]  col;
    logic [2:0]  col0;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] freq_in = '0;
  logic        freq_valid = 1'b0;
  logic        filt_s2, filt_s3, color_valid, busy;
  logic [31:0] red_val, green_val, blue_val, clear_val;
  logic [2:0]  color;
  logic        filt_s2_m0, filt_s3_m0, color_valid_m0, busy_m0;
  logic [31:0] red_val_m0, green_val_m0, blue_val_m0, clear_val_m0;
  logic [2:0]  color_m0;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  color_sense_sequencer #(.WIDTH(32), .DISCARD_WINDOWS(DISC), .MIN_CLEAR(50), .DOM_MARGIN(20)) dut (
    .clk(clk), .rst(rst), .start(start), .freq_in(freq_in), .freq_valid(freq_valid),
    .filt_s2(filt_s2), .filt_s3(filt_s3), .red_val(red_val), .green_val(green_val),
    .blue_val(blue_val), .clear_val(clear_val), .color(color), .color_valid(color_valid),
    .busy(busy)
  );

  color_sense_sequencer #(.WIDTH(32), .DISCARD_WINDOWS(DISC), .MIN_CLEAR(50), .DOM_MARGIN(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .freq_in(freq_in), .freq_valid(freq_valid),
    .filt_s2(filt_s2_m0), .filt_s3(filt_s3_m0), .red_val(red_val_m0), .green_val(green_val_m0),
    .blue_val(blue_val_m0), .clear_val(clear_val_m0), .color(color_m0),
    .color_valid(color_valid_m0), .busy(busy_m0)
  );

  function automatic logic [2:0] model_color(input longint r, input longint g, input longint b,
                                             input longint c, input longint m);
    longint top, low, runner;
    logic [2:0] win;
    if (c < 50) return 3'd0;
    if (r >= g && r >= b) begin top = r; win = 3'd1; end
    else if (g >= b)      begin top = g; win = 3'd2; end
    else                  begin top = b; win = 3'd3; end
    low = r;
    if (g < low) low = g;
    if (b < low) low = b;
    runner = r + g + b - top - low;
    return (top >= runner + m) ? win : 3'd7;
  endfunction

  function automatic logic [31:0] chan_val(input logic [31:0] a, input logic [31:0] b);
`ifdef COLOR_AVG_EN
    longint s;
    s = (longint'({32'b0, a}) + longint'({32'b0, b})) / 2;
    return s[31:0];
`else
    return (b === 32'hx) ? a : a;
`endif
  endfunction

  task automatic strobe(input logic [31:0] v);
    @(posedge clk); #1;
    freq_in    = v;
    freq_valid = 1'b1;
    @(posedge clk); #1;
    freq_valid = 1'b0;
    freq_in    = '0;
  endtask

  task automatic run_sweep(input string name, input win_t w, input logic [31:0] junk);
    exp_t e;
    int   n;
    e.r    = chan_val(w[0], w[1]);
    e.g    = chan_val(w[2], w[3]);
    e.b    = chan_val(w[4], w[5]);
    e.c    = chan_val(w[6], w[7]);
    e.col  = model_color(longint'({32'b0, e.r}), longint'({32'b0, e.g}), longint'({32'b0, e.b}), longint'({32'b0, e.c}), 20);
    e.col0 = model_color(longint'({32'b0, e.r}), longint'({32'b0, e.g}), longint'({32'b0, e.b}), longint'({32'b0, e.c}), 0);
    sb.push_back(e);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL %s busy_after_start: got %b expected 1", name, busy); end
    for (int ch = 0; ch < 4; ch++) begin
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({filt_s2, filt_s3} !== FCODE[ch])
        begin errors++; $display("[TB] FAIL %s filter_ch%0d: got %b expected %b", name, ch, {filt_s2, filt_s3}, FCODE[ch]); end
      for (int d = 0; d < DISC; d++) strobe(junk);
      for (int k = 0; k < NCAP; k++) strobe(w[2*ch+k]);
    end
    checks++;
    if (color_valid !== 1'b0) begin errors++; $display("[TB] FAIL %s early_valid: got %b expected 0", name, color_valid); end
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (color_valid !== 1'b1 && n < 8);
    checks++;
    if (n != 1) begin errors++; $display("[TB] FAIL %s valid_latency: got %0d expected 1 cycles", name, n); end
    checks++;
    if (color_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s result_missing: got valid=%b queued=%0d expected valid=1", name, color_valid, sb.size());
    end else begin
      e = sb.pop_front();
      checks++;
      if (red_val !== e.r) begin errors++; $display("[TB] FAIL %s red_val: got %0d expected %0d", name, red_val, e.r); end
      checks++;
      if (green_val !== e.g) begin errors++; $display("[TB] FAIL %s green_val: got %0d expected %0d", name, green_val, e.g); end
      checks++;
      if (blue_val !== e.b) begin errors++; $display("[TB] FAIL %s blue_val: got %0d expected %0d", name, blue_val, e.b); end
      checks++;
      if (clear_val !== e.c) begin errors++; $display("[TB] FAIL %s clear_val: got %0d expected %0d", name, clear_val, e.c); end
      checks++;
      if (color !== e.col) begin errors++; $display("[TB] FAIL %s color: got %0d expected %0d", name, color, e.col); end
      checks++;
      if (color_valid_m0 !== 1'b1 || color_m0 !== e.col0)
        begin errors++; $display("[TB] FAIL %s color_m0: got %0d/v%b expected %0d/v1", name, color_m0, color_valid_m0, e.col0); end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("[TB] FAIL %s busy_at_valid: got %b expected 1", name, busy); end
    end
    @(posedge clk); #1;
    checks++;
    if (color_valid !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("[TB] FAIL %s after_valid: got valid=%b busy=%b expected 0/0", name, color_valid, busy); end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    checks++;
    if ({filt_s2, filt_s3, busy, color_valid, color} !== 7'b0)
      begin errors++; $display("[TB] FAIL reset_ctrl: got %b expected 0000000", {filt_s2, filt_s3, busy, color_valid, color}); end
    checks++;
    if ({red_val, green_val, blue_val, clear_val} !== 128'b0)
      begin errors++; $display("[TB] FAIL reset_vals: got %0h expected 0", {red_val, green_val, blue_val, clear_val}); end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_start_ignored: got busy=%b expected 0", busy); end
  endtask

  task automatic test_red();
    run_sweep("red", '{400, 400, 120, 120, 100, 100, 700, 700}, 32'd999);
  endtask

  task automatic test_unknown_none();
    run_sweep("unknown", '{200, 200, 190, 190, 50, 50, 600, 600}, 32'd999);
    run_sweep("none", '{200, 200, 190, 190, 50, 50, 40, 40}, 32'd999);
    run_sweep("blue_zero_edge", '{0, 0, 0, 0, 25, 25, 50, 50}, 32'd999);
    run_sweep("clear_49", '{0, 0, 0, 0, 25, 25, 49, 49}, 32'd999);
  endtask

  task automatic test_tie();
    run_sweep("tie", '{300, 300, 300, 300, 0, 0, 500, 500}, 32'd999);
  endtask

  task automatic test_abort();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    strobe(32'd999);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 1", busy); end
    strobe(32'd400);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({filt_s2, filt_s3} !== 2'b11)
      begin errors++; $display("[TB] FAIL abort_restart_ignored: got %b expected 11", {filt_s2, filt_s3}); end
    strobe(32'd999);
    strobe(32'd120);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({filt_s2, filt_s3} !== 2'b01)
      begin errors++; $display("[TB] FAIL abort_blue_filter: got %b expected 01", {filt_s2, filt_s3}); end
    strobe(32'd999);
    @(posedge clk); #1;
    freq_in    = 32'd100;
    freq_valid = 1'b1;
    rst        = 1'b1;
    @(posedge clk); #1;
    freq_valid = 1'b0;
    checks++;
    if ({filt_s2, filt_s3, busy, color_valid, color} !== 7'b0)
      begin errors++; $display("[TB] FAIL abort_ctrl: got %b expected 0000000", {filt_s2, filt_s3, busy, color_valid, color}); end
    checks++;
    if ({red_val, green_val, blue_val, clear_val} !== 128'b0)
      begin errors++; $display("[TB] FAIL abort_vals: got %0h expected 0", {red_val, green_val, blue_val, clear_val}); end
    rst = 1'b0;
    @(posedge clk); #1;
    run_sweep("after_abort", '{50, 50, 500, 500, 100, 100, 300, 300}, 32'd7);
  endtask

  task automatic test_idle_overflow();
    for (int i = 0; i < 3; i++) begin
      strobe(32'hFFFFFFFF);
      checks++;
      if (busy !== 1'b0 || color_valid !== 1'b0)
        begin errors++; $display("[TB] FAIL idle_strobe%0d: got busy=%b valid=%b expected 0/0", i, busy, color_valid); end
    end
    checks++;
    if ({filt_s2, filt_s3} !== 2'b10 || red_val !== 32'd50 || green_val !== 32'd500)
      begin errors++; $display("[TB] FAIL idle_hold: got f=%b r=%0d g=%0d expected f=10 r=50 g=500", {filt_s2, filt_s3}, red_val, green_val); end
    run_sweep("all_ones", '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                            32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}, 32'hFFFFFFFF);
    checks++;
    if (clear_val !== 32'hFFFFFFFF || color !== 3'd7)
      begin errors++; $display("[TB] FAIL all_ones_result: got c=%0h col=%0d expected ffffffff/7", clear_val, color); end
  endtask

`ifdef COLOR_AVG_EN
  task automatic test_avg();
    run_sweep("avg", '{401, 399, 100, 102, 10, 12, 800, 600}, 32'd999);
    checks++;
    if (red_val !== 32'd400 || green_val !== 32'd101 || blue_val !== 32'd11 || clear_val !== 32'd700 || color !== 3'd1)
      begin errors++; $display("[TB] FAIL avg_values: got %0d %0d %0d %0d col %0d expected 400 101 11 700 col 1",
                                red_val, green_val, blue_val, clear_val, color); end
  endtask
`endif

  initial begin
    test_reset();
    test_red();
    test_unknown_none();
    test_tie();
    test_abort();
    test_idle_overflow();
`ifdef COLOR_AVG_EN
    test_avg();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/color_sense_sequencer.md
Name: color_sense_sequencer

Overview:
- Sits directly downstream of the sensor frequency counter on the rover colour-sensing path.
- Drives the TCS3200-style filter selects (S2/S3) through red, green, blue and clear.
- For each filter, throws away the counter windows taken while the filter settles, then latches the per-window frequency count.
- After all four channels are captured, classifies the surface colour and pulses a result to the navigation logic.

Parameters:
- WIDTH, 32, bit width of frequency counts (matches the counter's count output).
- DISCARD_WINDOWS, 1, counter windows discarded after each filter change (0..7).
- MIN_CLEAR, 50, clear-channel count below which the result is NONE.
- DOM_MARGIN, 20, amount by which the largest of R/G/B must exceed the second largest.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a measurement sweep.
- freq_in  in  WIDTH  count from the frequency counter; sampled only when freq_valid=1.
- freq_valid  in  1  one-cycle strobe at the end of each counter gate window.
- filt_s2  out  1  sensor filter select S2.
- filt_s3  out  1  sensor filter select S3.
- red_val  out  WIDTH  last captured red count.
- green_val  out  WIDTH  last captured green count.
- blue_val  out  WIDTH  last captured blue count.
- clear_val  out  WIDTH  last captured clear count.
- color  out  3  0=NONE, 1=RED, 2=GREEN, 3=BLUE, 7=UNKNOWN.
- color_valid  out  1  one-cycle pulse when color and the *_val outputs are updated.
- busy  out  1  high from the cycle after start is accepted until the color_valid cycle inclusive.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state is updated on posedge clk.
- Reset values:
  - all *_val outputs = 0; color = 0; color_valid = 0; busy = 0;
  - filt_s2 = 0, filt_s3 = 0 (red); FSM = IDLE; channel index = 0; discard counter = 0.
- Filter encoding {s2,s3}: red=00, green=11, blue=01, clear=10. Channel order is R, G, B, C.
- FSM states: IDLE, SELECT, DISCARD, CAPTURE, CLASSIFY.
  - IDLE: when start=1, go to SELECT with channel=R.
  - SELECT: drive that channel's filter code; load discard counter = DISCARD_WINDOWS; go to DISCARD. Duration is 1 cycle.
  - DISCARD: each freq_valid decrements the counter. When the counter is 0 (on entry, or after the decrement), go to CAPTURE. With DISCARD_WINDOWS=0, DISCARD lasts exactly one cycle.
  - CAPTURE: on the first freq_valid, latch freq_in into an internal channel register. If channel=C, go to CLASSIFY; otherwise advance the channel and go to SELECT.
  - CLASSIFY: 1 cycle. Update all four *_val outputs and color together, pulse color_valid, then return to IDLE. Filters hold at clear until the next sweep.
- Latency: color_valid comes 1 cycle after the freq_valid that captured the clear channel. A full sweep consumes 4*(DISCARD_WINDOWS+1) freq_valid strobes.
- Classification (combinational from the captured registers, registered in CLASSIFY):
  - clear < MIN_CLEAR → NONE.
  - Otherwise let max be the largest of R/G/B; ties resolve R > G > B. If max >= second + DOM_MARGIN → that channel's colour; else UNKNOWN.
  - The sum second + DOM_MARGIN is computed at WIDTH+1 bits, with no wrap.
- Boundaries:
  - start while busy: ignored.
  - freq_valid in IDLE or SELECT: ignored.
  - start and rst together: rst wins.
  - rst mid-sweep: return to the reset state; partial captures are discarded and *_val outputs are cleared.
  - freq_in=0 is a legal capture.
  - freq_in = all ones: no overflow in any compare.

Optional Feature:
- COLOR_AVG_EN defined:
  - CAPTURE takes two consecutive freq_valid windows per channel.
  - Stored value = (a+b)>>1, summed at WIDTH+1 bits, so the result never exceeds WIDTH bits.
  - A full sweep consumes 4*(DISCARD_WINDOWS+2) strobes.
- COLOR_AVG_EN undefined: single-window capture as described in Behaviour.

Decomposition:
- Shared package color_pkg:
  - colour code constants (COLOR_NONE/RED/GREEN/BLUE/UNKNOWN);
  - filter code constants (FILT_RED/GREEN/BLUE/CLEAR);
  - FSM state typedef;
  - channel index typedef (2 bits).
- One sub-module: color_classifier, purely combinational (R, G, B, C, MIN_CLEAR, DOM_MARGIN → color), so it can be verified exhaustively on its own.

Test Plan:
- Reset, then start. Feed freq_valid strobes with values: R discard 999/capture 400, G 999/120, B 999/100, C 999/700. Required: filters step 00,11,01,10; red_val=400, green_val=120, blue_val=100, clear_val=700; color=1; color_valid pulses once, 1 cycle after the clear capture.
- Captures R=200, G=190, B=50, C=600 → color=7 (UNKNOWN). Repeat with C=40 → color=0 (NONE).
- Tie: R=G=300, B=0, C=500 with DOM_MARGIN=0 → color=1 (red priority). With DOM_MARGIN=20 → color=7.
- Assert start again mid-sweep (ignored). Assert rst during the B capture → next cycle filters=00, busy=0, all *_val=0. A fresh sweep then completes normally.
- freq_valid pulses in IDLE plus freq_in=32'hFFFFFFFF on all channels → no state change while idle. After the sweep: color=7, no overflow, clear_val=32'hFFFFFFFF.
- With COLOR_AVG_EN: captures R windows 401/399, G 100/102, B 10/12, C 800/600 → red_val=400, green_val=101, blue_val=11, clear_val=700, color=1.
